// File: rtl/syrk_result_collector.sv
// Captures the serial SYRK result stream row-major into a buffer and serves registered reads once complete.
// Optional running checksum enabled by defining SYRK_COLLECT_CHECKSUM_EN.
module syrk_result_collector #(
  parameter int unsigned N  = 100,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  input  logic          clr,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          done,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [DW-1:0] checksum
);

  localparam int unsigned DEPTH = N * N;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic          wr_en;

  // Depth is the full address space so any rd_addr indexes safely; only the first DEPTH words are used.
  logic [DW-1:0] mem [0:(1<<AW)-1];

  assign wr_en = din_valid && !clr && (state != DONE);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == DONE && rd_en) begin
        rd_valid <= 1'b1;
        rd_data  <= ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr] : '0;
      end

      if (clr) begin
        state    <= IDLE;
        wr_ptr   <= '0;
        count    <= '0;
        done     <= 1'b0;
        overflow <= 1'b0;
      end else if (din_valid) begin
        case (state)
          IDLE, CAPTURE: begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
            if (count == LAST_W) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CAPTURE;
            end
          end
          DONE:    overflow <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SYRK_COLLECT_CHECKSUM_EN
  logic [DW-1:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       acc <= '0;
    else if (clr)   acc <= '0;
    else if (wr_en) acc <= acc + din;
  end

  assign checksum = acc;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_syrk_result_collector.sv
// Scoreboard bench for syrk_result_collector with N=4; checksum expectations follow SYRK_COLLECT_CHECKSUM_EN.
module tb_syrk_result_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          clr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          done;
  logic [AW:0]   count;
  logic          overflow;
  logic [DW-1:0] checksum;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_mem [16];
  int unsigned   m_cnt;
  logic [DW-1:0] m_sum;
  logic          m_done;
  logic          m_ovf;

  syrk_result_collector #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .count(count), .overflow(overflow), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_ck();
`ifdef SYRK_COLLECT_CHECKSUM_EN
    return m_sum;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_sum = '0; m_done = 1'b0; m_ovf = 1'b0;
    q.delete();
  endtask

  // One clock: drive at negedge, update model and scoreboard, then check read port after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic c,
                       input logic r, input logic [AW-1:0] a);
    logic [DW-1:0] e;
    @(negedge clk);
    din_valid = v; din = d; clr = c; rd_en = r; rd_addr = a;
    if (r && m_done) q.push_back((a < 16) ? m_mem[a[3:0]] : '0);
    if (c) begin
      m_cnt = 0; m_sum = '0; m_done = 1'b0; m_ovf = 1'b0;
    end else if (v) begin
      if (!m_done) begin
        m_mem[m_cnt[3:0]] = d;
        m_cnt = m_cnt + 1;
        m_sum = m_sum + d;
        if (m_cnt == 16) m_done = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    din_valid = 1'b0; clr = 1'b0; rd_en = 1'b0;
    if (rd_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected: rd_valid=1 rd_data=%0d, required rd_valid=0", rd_data);
      end else begin
        e = q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0d, expected %0d", rd_data, e);
        end
      end
    end else if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rd_valid_missing: rd_valid=0, required 1");
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    din = '0; din_valid = 0; clr = 0; rd_en = 0; rd_addr = '0; rst = 1'b1;
    do_reset();
    checks++;
    if ({rd_data, rd_valid, done, count, overflow, checksum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd_data=%0d rd_valid=%b done=%b count=%0d ovf=%b ck=%0d, required all 0",
               rd_data, rd_valid, done, count, overflow, checksum);
    end
    cycle(0, '0, 0, 1, 5'd3);
    cycle(0, '0, 0, 1, 5'd0);
  endtask

  task automatic test_full_capture();
    for (int i = 1; i <= 16; i++) begin
      cycle(1, DW'(i), 0, 1, 5'd0);
      if (i == 15) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_early: got %b, expected 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b, expected 1", done); end
    checks++;
    if (count !== 6'd16) begin errors++; $display("FAIL full_count: got %0d, expected 16", count); end
    checks++;
    if (checksum !== exp_ck()) begin errors++; $display("FAIL full_checksum: got %0d, expected %0d", checksum, exp_ck()); end
    cycle(0, '0, 0, 1, 5'd5);
    for (int a = 0; a < 16; a++) cycle(0, '0, 0, 1, AW'(a));
  endtask

  task automatic test_overflow();
    cycle(1, 32'd99, 0, 1, 5'd0);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    checks++;
    if (count !== 6'd16) begin errors++; $display("FAIL ovf_count: got %0d, expected 16", count); end
    checks++;
    if (checksum !== exp_ck()) begin errors++; $display("FAIL ovf_checksum: got %0d, expected %0d", checksum, exp_ck()); end
    cycle(0, '0, 0, 1, 5'd15);
  endtask

  task automatic test_oor_clear();
    cycle(0, '0, 0, 1, 5'd20);
    cycle(0, '0, 0, 1, 5'd31);
    cycle(1, 32'd77, 1, 0, 5'd0);
    checks++;
    if ({done, count, overflow, checksum} !== '0) begin
      errors++;
      $display("FAIL clr_state: done=%b count=%0d ovf=%b ck=%0d, required all 0", done, count, overflow, checksum);
    end
    cycle(0, '0, 0, 1, 5'd1);
  endtask

  task automatic test_gapped();
    for (int k = 0; k < 31; k++) begin
      cycle((k % 2) == 0, DW'(k / 2 + 1), 0, 1, 5'd0);
      if (k == 7) begin
        checks++;
        if (count !== 6'd4) begin errors++; $display("FAIL gap_count: got %0d, expected 4", count); end
      end
      if (k == 8) begin
        checks++;
        if (count !== 6'd5) begin errors++; $display("FAIL gap_count_step: got %0d, expected 5", count); end
      end
      if (k == 29) begin
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL gap_done_early: got %b, expected 0", done); end
      end
    end
    checks++;
    if (done !== 1'b1 || count !== 6'd16) begin
      errors++;
      $display("FAIL gap_done: done=%b count=%0d, required 1 and 16", done, count);
    end
    for (int a = 15; a >= 0; a--) cycle(0, '0, 0, 1, AW'(a));
  endtask

  task automatic test_reset_mid_capture();
    cycle(0, '0, 1, 0, 5'd0);
    for (int i = 0; i < 7; i++) cycle(1, DW'(200 + i), 0, 0, 5'd0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({rd_data, rd_valid, done, count, overflow, checksum} !== '0) begin
      errors++;
      $display("FAIL async_reset: rd_data=%0d done=%b count=%0d ck=%0d, required all 0", rd_data, done, count, checksum);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) cycle(1, DW'(100 + i), 0, 0, 5'd0);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL restream_done: got %b, expected 1", done); end
    checks++;
    if (checksum !== exp_ck()) begin errors++; $display("FAIL restream_checksum: got %0d, expected %0d", checksum, exp_ck()); end
    cycle(0, '0, 0, 1, 5'd0);
    cycle(0, '0, 0, 1, 5'd6);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_capture();
    test_overflow();
    test_oor_clear();
    test_gapped();
    test_reset_mid_capture();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/syrk_result_collector.md
# syrk_result_collector

Downstream capture stage for the SYRK `Matrix` engine. It takes the serial 32-bit result stream (`Dout` qualified by `flag`) and stores the N×N result matrix row-major in an internal buffer. When the matrix is complete it raises `done` and exposes a registered random-access read port for the host or bench. It also keeps an element count, an overflow flag and an optional running checksum.

## Interface
- `N`, 100, matrix dimension; N*N words are captured per result.
- `DW`, 32, data word width; matches `Matrix` `Dout`.
- `AW`, 14, buffer address width; requires N*N ≤ 2^AW.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `din`  in  DW  result word, wired to `Matrix` `Dout`.
- `din_valid`  in  1  word qualifier, wired to `Matrix` `flag`.
- `clr`  in  1  synchronous clear; re-arms capture.
- `rd_en`  in  1  read request.
- `rd_addr`  in  AW  row-major read address (row*N+col).
- `rd_data`  out  DW  registered read data.
- `rd_valid`  out  1  `rd_data` valid strobe.
- `done`  out  1  N*N words captured.
- `count`  out  AW+1  words captured so far.
- `overflow`  out  1  sticky; a word arrived while in DONE.
- `checksum`  out  DW  modulo-2^DW sum of captured words.

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE → CAPTURE on the first `din_valid`. That word is written to address 0.
- CAPTURE: every `din_valid` cycle writes `din` to `mem[wr_ptr]`, then increments `wr_ptr` and `count`. Cycles with `din_valid`=0 hold all state; gaps are legal.
- CAPTURE → DONE on the edge that writes word N*N-1. `done` goes high that edge.
- DONE: `din_valid` drops the word and sets `overflow`. Memory, `count` and `checksum` do not change.
- `clr` from any state → IDLE. It zeroes `wr_ptr`, `count`, `checksum`, `done` and `overflow`; memory is not cleared. If `clr` and `din_valid` coincide, `clr` wins and the word is dropped.
- Reads are honoured only in DONE. `rd_en` in IDLE or CAPTURE is ignored and `rd_valid` stays 0.
- A read with `rd_addr` ≥ N*N returns 0 with `rd_valid`=1.
- A read and a dropped overflow write in the same DONE cycle are independent; both take effect.
- Arithmetic:
  - `checksum` accumulates `din` with DW-bit wrap-around, no carry out.
  - `count` saturates at N*N by construction.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE; `rd_data`=0, `rd_valid`=0, `done`=0, `count`=0, `overflow`=0, `checksum`=0. Memory contents are undefined.
- Reset asserted mid-capture aborts immediately. The first `din_valid` after release starts again at address 0.
- Write latency: `count`, `checksum` and `done` reflect a word on the same edge that samples it.
- Read latency: 1 cycle. `rd_en` sampled at edge k gives `rd_data`/`rd_valid` after edge k; `rd_valid` is a 1-cycle pulse per request.
- Back-to-back `rd_en` on every cycle is supported, giving one result per cycle.
- Throughput: one captured word per clock, matching `Matrix` output rate.

## Configuration
- `SYRK_COLLECT_CHECKSUM_EN`
  - Defined: the checksum accumulator is built and `checksum` behaves as above.
  - Undefined: no accumulator logic; `checksum` is tied to 0 in all states.
  - All other behaviour is identical either way.

## Test plan
- Reset: drive `rst`=0 mid-run → all outputs 0, `done`=0, IDLE; `rd_en` then gives no `rd_valid`.
- Full capture (N=4): stream 1..16 with `din_valid` continuous → `done`=1 on the 16th edge, `count`=16, `checksum`=136 (when `SYRK_COLLECT_CHECKSUM_EN` is defined). Then `rd_addr`=5 gives `rd_data`=6 one cycle later.
- Gapped stream: same 16 words with `din_valid` alternating 1/0 → identical memory; `count` steps only on valid cycles; `done` after 31 cycles.
- Overflow: 17th valid word 99 after `done` → `overflow`=1, `count`=16, `checksum`=136, `rd_addr`=0 still reads 1.
- Out-of-range read and clear:
  - In DONE, `rd_addr`=20 → `rd_data`=0 with `rd_valid`=1.
  - Then `clr` plus `din_valid` in the same cycle → IDLE, `count`=0, `overflow`=0, word dropped.
- Reset mid-capture after 7 words, then restream 16 words 100..115 → `done`, `rd_addr`=0 reads 100, `checksum`=1720.
